// File: rtl/opsel_ctrl.sv
// Multicycle control FSM for an adder-only RV32I subset datapath (ADDI/LUI/AUIPC/JAL).
// Fetches one word per FETCH visit and sequences operand selects and write enables.
module opsel_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [31:0] imm_out,
  output logic        sel_operb,
  output logic [1:0]  opa_sel,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rd_addr,
  output logic        reg_we,
  output logic        pc_we,
  output logic        instr_retired,
  output logic        illegal
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_PCUPD, S_TRAP} state_t;
  typedef enum logic [1:0] {C_ADDI, C_LUI, C_AUIPC, C_JAL} cls_t;

  localparam logic [1:0] OPA_RS1  = 2'b00;
  localparam logic [1:0] OPA_IMM  = 2'b01;
  localparam logic [1:0] OPA_ZERO = 2'b10;
  localparam logic [1:0] OPA_FOUR = 2'b11;

  state_t      state, state_nxt;
  cls_t        cls, cls_dec;
  logic [31:0] ir, imm, imm_dec;
  logic        legal_dec, illegal_q;

  // Decode works on the latched IR, so outputs never depend on the live instr bus.
  always_comb begin
    legal_dec = 1'b0;
    cls_dec   = C_ADDI;
    imm_dec   = '0;
    case (ir[6:0])
      7'b0010011: begin
        if (ir[14:12] == 3'b000) begin
          legal_dec = 1'b1;
          cls_dec   = C_ADDI;
          imm_dec   = {{20{ir[31]}}, ir[31:20]};
        end
      end
      7'b0110111: begin
        legal_dec = 1'b1;
        cls_dec   = C_LUI;
        imm_dec   = {ir[31:12], 12'b0};
      end
      7'b0010111: begin
        legal_dec = 1'b1;
        cls_dec   = C_AUIPC;
        imm_dec   = {ir[31:12], 12'b0};
      end
      7'b1101111: begin
        legal_dec = 1'b1;
        cls_dec   = C_JAL;
        imm_dec   = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      ir        <= '0;
      imm       <= '0;
      cls       <= C_ADDI;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && instr_valid)
        ir <= instr;
      if (state == S_DECODE) begin
        if (legal_dec) begin
          imm <= imm_dec;
          cls <= cls_dec;
        end else begin
          illegal_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    instr_ready   = 1'b0;
    sel_operb     = 1'b0;
    opa_sel       = OPA_RS1;
    reg_we        = 1'b0;
    pc_we         = 1'b0;
    instr_retired = 1'b0;
    case (state)
      S_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid)
          state_nxt = S_DECODE;
      end
      S_DECODE: state_nxt = legal_dec ? S_EXEC : S_TRAP;
      S_EXEC: begin
        reg_we    = (ir[11:7] != 5'd0);
        state_nxt = S_PCUPD;
        case (cls)
          C_ADDI:  begin opa_sel = OPA_RS1;  sel_operb = 1'b1; end
          C_LUI:   begin opa_sel = OPA_ZERO; sel_operb = 1'b1; end
          C_AUIPC: begin opa_sel = OPA_IMM;  sel_operb = 1'b0; end
          default: begin opa_sel = OPA_FOUR; sel_operb = 1'b0; end
        endcase
      end
      S_PCUPD: begin
        pc_we         = 1'b1;
        instr_retired = 1'b1;
        state_nxt     = S_FETCH;
        opa_sel       = (cls == C_JAL) ? OPA_IMM : OPA_FOUR;
      end
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_FETCH;
    endcase
  end

  assign imm_out  = imm;
  assign rd_addr  = ir[11:7];
  assign rs1_addr = ir[19:15];
  assign illegal  = illegal_q;

endmodule

// File: doc/opsel_ctrl.md
# opsel_ctrl

Multicycle control FSM that fetches one instruction word at a time, decodes a small RV32I subset, and drives the datapath control: operand-B select (PC vs immediate), the immediate value, operand-A select, register write enable/address and PC update. It is the producer side of the operand-B mux: it generates `sel_operb` and the 32-bit immediate that the mux consumes, and sequences the adder-only ALU over several cycles per instruction.

## Interface
Parameters: none.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `instr_valid`  in  1  instruction memory has a word on `instr`
- `instr`  in  32  instruction word
- `instr_ready`  out  1  controller accepts `instr` this cycle
- `imm_out`  out  32  immediate to operand-B mux number input and operand-A mux
- `sel_operb`  out  1  1 = operand B is `imm_out`, 0 = operand B is PC
- `opa_sel`  out  2  operand A: 00 rs1 data, 01 `imm_out`, 10 zero, 11 constant 4
- `rs1_addr`  out  5  register-file read address
- `rd_addr`  out  5  register-file write address
- `reg_we`  out  1  register-file write enable (ALU result)
- `pc_we`  out  1  load PC from ALU result
- `instr_retired`  out  1  one-cycle pulse per completed instruction
- `illegal`  out  1  sticky: unsupported instruction decoded

## Operation
- ALU always adds (A + B); this block only selects operands and enables writes.
- States: FETCH, DECODE, EXEC, PCUPD, TRAP.
- FETCH: `instr_ready`=1. On `instr_valid`&&`instr_ready`, latch `instr` into IR, go DECODE. Otherwise stay.
- DECODE: classify opcode; register immediate and class. Legal → EXEC; else → TRAP.
  - ADDI: opcode 0010011, funct3 000; imm_I = sext(instr[31:20]).
  - LUI: opcode 0110111; imm_U = {instr[31:12], 12'b0}.
  - AUIPC: opcode 0010111; imm_U.
  - JAL: opcode 1101111; imm_J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- EXEC (reg_we asserted unless rd = 0):
  - ADDI: opa_sel=00, sel_operb=1 (rs1 + imm).
  - LUI: opa_sel=10, sel_operb=1 (0 + imm).
  - AUIPC: opa_sel=01, sel_operb=0 (imm + PC).
  - JAL: opa_sel=11, sel_operb=0 (link = PC + 4).
- PCUPD: pc_we=1, instr_retired=1, then → FETCH.
  - Non-JAL: opa_sel=11, sel_operb=0 (PC + 4).
  - JAL: opa_sel=01, sel_operb=0 (PC + imm_J).
- TRAP: `illegal`=1, `instr_ready`=0, all enables 0; exit only by reset.
- `rd_addr` = IR[11:7], `rs1_addr` = IR[19:15] in all states after DECODE; `imm_out` holds its value until the next DECODE.
- In every state other than EXEC and PCUPD, `reg_we`=`pc_we`=0; `opa_sel`/`sel_operb` idle at 00/0.

## Timing
- Moore outputs: functions of state, IR and imm register only; no combinational path from `instr`/`instr_valid` except none (`instr_ready` = state==FETCH).
- Minimum 4 cycles per instruction: handshake edge → DECODE → EXEC → PCUPD → FETCH.
- `imm_out` valid from the first EXEC cycle onward; registered at DECODE→EXEC edge.
- Reset (async, any state, including mid-instruction): state=FETCH, IR=0, imm=0, `illegal`=0; outputs `instr_ready`=1, `imm_out`=0, `sel_operb`=0, `opa_sel`=00, `rs1_addr`=`rd_addr`=0, `reg_we`=`pc_we`=`instr_retired`=0. No partial write is emitted after reset deasserts.
- `instr_valid` held high across many cycles: only one word is consumed per FETCH visit.

## Test plan
- Reset then `instr`=0xFFF00293 (ADDI x5,x0,-1) valid → DECODE next; EXEC: imm_out=0xFFFFFFFF, opa_sel=00, sel_operb=1, reg_we=1, rd_addr=5; PCUPD: pc_we=1, opa_sel=11, sel_operb=0, instr_retired=1; FETCH 4 cycles after accept.
- 0x123450B7 (LUI x1,0x12345) → EXEC imm_out=0x12345000, opa_sel=10, sel_operb=1, reg_we=1, rd_addr=1.
- 0x00001117 (AUIPC x2,1) → EXEC imm_out=0x00001000, opa_sel=01, sel_operb=0, reg_we=1; 0x008000EF (JAL x1,+8) → EXEC opa_sel=11, sel_operb=0, reg_we=1; PCUPD imm_out=0x00000008, opa_sel=01, pc_we=1.
- 0x00100013 (ADDI x0,x0,1) → reg_we stays 0 throughout; pc_we=1 in PCUPD.
- 0x00000000 → TRAP: illegal=1, instr_ready=0 indefinitely with instr_valid held 1; assert rst → illegal=0, instr_ready=1.
- Assert rst during EXEC of an ADDI → reg_we/pc_we drop immediately; after release, no instr_retired until a new word is accepted; instr_valid low for 5 cycles in FETCH → no state change.
